// File: rtl/uc_secuenciador_if.sv
`default_nettype none
// ============================================================================
// uc_secuenciador_if : control-unit sequencer bus (UC_ES loop, memory, strobes)
// Revision 1.0
// ============================================================================
interface uc_secuenciador_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             mem_ready;
  logic [1:0]       instr_op;
  logic [3:0]       next_state;
  logic [3:0]       Q;
  logic [1:0]       x;
  logic             mem_rd;
  logic             mem_wr;
  logic             ir_we;
  logic             pc_we;
  logic             alu_en;
  logic             alu_src;
  logic             reg_we;
  logic             reg_src_mem;
  logic             instr_done;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output en, mem_ready, instr_op, next_state,
    input  Q, x, mem_rd, mem_wr, ir_we, pc_we, alu_en, alu_src,
           reg_we, reg_src_mem, instr_done, illegal, instr_count
  );

  modport slave (
    input  en, mem_ready, instr_op, next_state,
    output Q, x, mem_rd, mem_wr, ir_we, pc_we, alu_en, alu_src,
           reg_we, reg_src_mem, instr_done, illegal, instr_count
  );
endinterface
`default_nettype wire

// File: rtl/uc_secuenciador.sv
`default_nettype none
// ============================================================================
// uc_secuenciador : state register, opcode latch and Moore control decoder
// Revision 1.0
// ============================================================================
module uc_secuenciador #(
  parameter int CNT_W = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  uc_secuenciador_if.slave  bus
);
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_ALU_RR   = 4'd2,
    S_ALU_IMM  = 4'd3,
    S_STORE    = 4'd4,
    S_LOAD     = 4'd5,
    S_WB_ALU   = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_WB_LOAD  = 4'd8
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       x_q, x_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;
  logic             wait_state, advance, retire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      x_q       <= 2'b00;
      count_q   <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      count_q   <= count_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    wait_state = state_q inside {S_FETCH, S_LOAD, S_STORE};
    advance    = bus.en & ~(wait_state & ~bus.mem_ready);
    retire     = advance & (state_q inside {S_WB_ALU, S_WB_LOAD, S_STORE});

    state_d   = state_q;
    x_d       = x_q;
    count_d   = count_q;
    done_d    = 1'b0;
    illegal_d = illegal_q;

    if (advance) begin
      // Out-of-range next state recovers to FETCH and is remembered until reset
      if (bus.next_state > 4'd8) begin
        state_d   = S_FETCH;
        illegal_d = 1'b1;
      end else begin
        state_d = state_t'(bus.next_state);
      end
      if (state_q == S_FETCH) x_d = bus.instr_op;
    end

    if (retire) begin
      count_d = count_q + CNT_W'(1);
      done_d  = 1'b1;
    end
  end

  logic mem_rd, mem_wr, ir_we, pc_we, alu_en, alu_src, reg_we, reg_src_mem;

  always_comb begin
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    alu_en      = 1'b0;
    alu_src     = 1'b0;
    reg_we      = 1'b0;
    reg_src_mem = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_rd = 1'b1;
        ir_we  = bus.mem_ready & bus.en;
      end
      S_DECODE:  pc_we = bus.en;
      S_ALU_RR:  alu_en = 1'b1;
      S_ALU_IMM, S_MEM_ADDR: begin
        alu_en  = 1'b1;
        alu_src = 1'b1;
      end
      S_LOAD:    mem_rd = 1'b1;
      S_STORE:   mem_wr = 1'b1;
      S_WB_ALU:  reg_we = bus.en;
      S_WB_LOAD: begin
        reg_we      = bus.en;
        reg_src_mem = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.Q           = state_q;
  assign bus.x           = x_q;
  assign bus.instr_count = count_q;
  assign bus.instr_done  = done_q;
  assign bus.illegal     = illegal_q;
  assign bus.mem_rd      = mem_rd;
  assign bus.mem_wr      = mem_wr;
  assign bus.ir_we       = ir_we;
  assign bus.pc_we       = pc_we;
  assign bus.alu_en      = alu_en;
  assign bus.alu_src     = alu_src;
  assign bus.reg_we      = reg_we;
  assign bus.reg_src_mem = reg_src_mem;
endmodule
`default_nettype wire

// File: tb/tb_uc_secuenciador.sv
`default_nettype none
// ============================================================================
// tb_uc_secuenciador : directed bench with a behavioural UC_ES next-state loop
// Revision 1.0
// ============================================================================
module tb_uc_secuenciador;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_tot  = 0;
  logic       force_ns  = 1'b0;
  logic [3:0] force_val = 4'd0;

  uc_secuenciador_if #(.CNT_W(CNT_W)) bus();

  uc_secuenciador #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural UC_ES closing the combinational loop, with an override for fault injection
  always_comb begin
    bus.next_state = 4'd0;
    case (bus.Q)
      4'd0: bus.next_state = 4'd1;
      4'd1: bus.next_state = bus.x[1] ? 4'd7 : (bus.x[0] ? 4'd3 : 4'd2);
      4'd2, 4'd3: bus.next_state = 4'd6;
      4'd7: bus.next_state = bus.x[0] ? 4'd4 : 4'd5;
      4'd5: bus.next_state = 4'd8;
      default: bus.next_state = 4'd0;
    endcase
    if (force_ns) bus.next_state = force_val;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.en = 1'b1; bus.mem_ready = 1'b0; bus.instr_op = 2'b00;
    rst = 1'b1;
    #1;
    step();
    n_tot++; if (bus.Q !== 4'd0) $display("FAIL rst_q got %0d want 0", bus.Q); else n_pass++;
    n_tot++; if (bus.x !== 2'b00) $display("FAIL rst_x got %0d want 0", bus.x); else n_pass++;
    n_tot++; if (bus.instr_count !== 4'd0) $display("FAIL rst_cnt got %0d want 0", bus.instr_count); else n_pass++;
    n_tot++; if (bus.instr_done !== 1'b0 || bus.illegal !== 1'b0) $display("FAIL rst_flags got done=%b ill=%b want 0 0", bus.instr_done, bus.illegal); else n_pass++;
    n_tot++; if ({bus.mem_rd, bus.mem_wr, bus.ir_we, bus.pc_we, bus.alu_en, bus.alu_src, bus.reg_we, bus.reg_src_mem} !== 8'b1000_0000)
      $display("FAIL rst_strobes got %b want 10000000", {bus.mem_rd, bus.mem_wr, bus.ir_we, bus.pc_we, bus.alu_en, bus.alu_src, bus.reg_we, bus.reg_src_mem}); else n_pass++;
    bus.mem_ready = 1'b1;
    #1;
    n_tot++; if (bus.ir_we !== 1'b1) $display("FAIL rst_ir_we got %b want 1", bus.ir_we); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_alu_rr();
    logic [3:0] eq [5] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd0};
    logic       eir[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       epc[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       erw[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       edn[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bus.instr_op = 2'b00; bus.mem_ready = 1'b1; bus.en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) step();
      n_tot++; if (bus.Q !== eq[c]) $display("FAIL rr_q c%0d got %0d want %0d", c, bus.Q, eq[c]); else n_pass++;
      n_tot++; if ({bus.ir_we, bus.pc_we, bus.reg_we, bus.instr_done} !== {eir[c], epc[c], erw[c], edn[c]})
        $display("FAIL rr_strb c%0d got %b want %b", c, {bus.ir_we, bus.pc_we, bus.reg_we, bus.instr_done}, {eir[c], epc[c], erw[c], edn[c]}); else n_pass++;
    end
    n_tot++; if (bus.alu_src !== 1'b0 || bus.instr_count !== 4'd1) $display("FAIL rr_cnt got %0d want 1", bus.instr_count); else n_pass++;
  endtask

  task automatic test_load_wait();
    logic [3:0] eq [9] = '{4'd0, 4'd1, 4'd7, 4'd5, 4'd5, 4'd5, 4'd5, 4'd8, 4'd0};
    logic       emr[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       erd[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       esm[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bus.instr_op = 2'b10;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) step();
      bus.mem_ready = emr[c];
      #1;
      n_tot++; if (bus.Q !== eq[c]) $display("FAIL ld_q c%0d got %0d want %0d", c, bus.Q, eq[c]); else n_pass++;
      n_tot++; if ({bus.mem_rd, bus.reg_src_mem} !== {erd[c], esm[c]})
        $display("FAIL ld_strb c%0d got %b want %b", c, {bus.mem_rd, bus.reg_src_mem}, {erd[c], esm[c]}); else n_pass++;
      if (c > 0 && c < 8) begin
        n_tot++; if (bus.instr_done !== 1'b0) $display("FAIL ld_done c%0d got %b want 0", c, bus.instr_done); else n_pass++;
      end
    end
    n_tot++; if (bus.instr_done !== 1'b1 || bus.instr_count !== 4'd2)
      $display("FAIL ld_end got done=%b cnt=%0d want 1 2", bus.instr_done, bus.instr_count); else n_pass++;
  endtask

  task automatic test_store_reset();
    bus.instr_op = 2'b11; bus.mem_ready = 1'b1;
    step(); step(); step();
    bus.mem_ready = 1'b0;
    #1;
    n_tot++; if (bus.Q !== 4'd4 || bus.mem_wr !== 1'b1) $display("FAIL st_in got q=%0d wr=%b want 4 1", bus.Q, bus.mem_wr); else n_pass++;
    step();
    n_tot++; if (bus.Q !== 4'd4 || bus.mem_wr !== 1'b1) $display("FAIL st_wait got q=%0d wr=%b want 4 1", bus.Q, bus.mem_wr); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_tot++; if (bus.mem_wr !== 1'b0 || bus.Q !== 4'd0) $display("FAIL st_async got q=%0d wr=%b want 0 0", bus.Q, bus.mem_wr); else n_pass++;
    n_tot++; if (bus.instr_count !== 4'd0 || bus.instr_done !== 1'b0)
      $display("FAIL st_cnt got cnt=%0d done=%b want 0 0", bus.instr_count, bus.instr_done); else n_pass++;
    step();
    n_tot++; if (bus.instr_done !== 1'b0 || bus.Q !== 4'd0) $display("FAIL st_hold got q=%0d done=%b want 0 0", bus.Q, bus.instr_done); else n_pass++;
    rst = 1'b0;
    bus.mem_ready = 1'b1;
  endtask

  task automatic test_illegal();
    bus.instr_op = 2'b00;
    step(); step(); step();
    n_tot++; if (bus.Q !== 4'd6) $display("FAIL il_pre got q=%0d want 6", bus.Q); else n_pass++;
    force_val = 4'd10; force_ns = 1'b1;
    step();
    force_ns = 1'b0;
    n_tot++; if (bus.Q !== 4'd0 || bus.illegal !== 1'b1) $display("FAIL il_set got q=%0d ill=%b want 0 1", bus.Q, bus.illegal); else n_pass++;
    step(); step(); step(); step();
    n_tot++; if (bus.Q !== 4'd0 || bus.instr_done !== 1'b1) $display("FAIL il_next got q=%0d done=%b want 0 1", bus.Q, bus.instr_done); else n_pass++;
    n_tot++; if (bus.illegal !== 1'b1) $display("FAIL il_sticky got %b want 1", bus.illegal); else n_pass++;
    rst = 1'b1;
    #1;
    n_tot++; if (bus.illegal !== 1'b0) $display("FAIL il_clr got %b want 0", bus.illegal); else n_pass++;
    step();
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    logic [3:0] eq[4] = '{4'd1, 4'd3, 4'd6, 4'd0};
    int pulses = 0;
    bus.instr_op = 2'b01; bus.mem_ready = 1'b1; bus.en = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      for (int s = 0; s < 4; s++) begin
        step();
        if (bus.instr_done === 1'b1) pulses++;
        n_tot++; if (bus.Q !== eq[s]) $display("FAIL wr_q i%0d s%0d got %0d want %0d", i, s, bus.Q, eq[s]); else n_pass++;
      end
      n_tot++; if (bus.instr_count !== 4'(i % 16)) $display("FAIL wr_cnt i%0d got %0d want %0d", i, bus.instr_count, i % 16); else n_pass++;
    end
    n_tot++; if (pulses != 17) $display("FAIL wr_pulses got %0d want 17", pulses); else n_pass++;
  endtask

  task automatic test_en_stall();
    bus.en = 1'b0; bus.instr_op = 2'b10;
    #1;
    n_tot++; if (bus.ir_we !== 1'b0) $display("FAIL en_ir got %b want 0", bus.ir_we); else n_pass++;
    for (int k = 0; k < 2; k++) begin
      step();
      n_tot++; if (bus.Q !== 4'd0 || bus.x !== 2'b01 || bus.ir_we !== 1'b0)
        $display("FAIL en_fetch k%0d got q=%0d x=%0d ir=%b want 0 1 0", k, bus.Q, bus.x, bus.ir_we); else n_pass++;
    end
    bus.instr_op = 2'b00; bus.en = 1'b1;
    #1;
    n_tot++; if (bus.ir_we !== 1'b1) $display("FAIL en_ir_on got %b want 1", bus.ir_we); else n_pass++;
    step();
    n_tot++; if (bus.Q !== 4'd1 || bus.x !== 2'b00 || bus.pc_we !== 1'b1)
      $display("FAIL en_dec got q=%0d x=%0d pc=%b want 1 0 1", bus.Q, bus.x, bus.pc_we); else n_pass++;
    bus.en = 1'b0;
    #1;
    n_tot++; if (bus.pc_we !== 1'b0) $display("FAIL en_pc got %b want 0", bus.pc_we); else n_pass++;
    for (int k = 0; k < 2; k++) begin
      step();
      n_tot++; if (bus.Q !== 4'd1 || bus.instr_count !== 4'd1 || bus.pc_we !== 1'b0)
        $display("FAIL en_dechold k%0d got q=%0d cnt=%0d pc=%b want 1 1 0", k, bus.Q, bus.instr_count, bus.pc_we); else n_pass++;
    end
    bus.en = 1'b1;
    step(); step(); step();
    n_tot++; if (bus.Q !== 4'd0 || bus.instr_count !== 4'd2 || bus.instr_done !== 1'b1)
      $display("FAIL en_end got q=%0d cnt=%0d done=%b want 0 2 1", bus.Q, bus.instr_count, bus.instr_done); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_alu_rr();
    test_load_wait();
    test_store_reset();
    test_illegal();
    test_wrap();
    test_en_stall();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/uc_secuenciador.md
# uc_secuenciador

State register, opcode latch and control-word decoder for the multicycle control unit. It sits directly downstream of the next-state logic `UC_ES`. It registers `UC_ES.State` into `Q`, latches the 2-bit opcode `x` that `UC_ES` consumes, and decodes `Q` into datapath strobes. It also stalls the FSM on memory handshakes and counts retired instructions.

## Interface
- `CNT_W`, default 16: width of the retired-instruction counter.

- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `en`  in  1  global advance enable; 0 freezes all registers.
- `mem_ready`  in  1  memory handshake; completes a read or write in a wait state.
- `instr_op`  in  2  opcode field of the instruction word currently on the memory bus.
- `next_state`  in  4  next state from `UC_ES.State`.
- `Q`  out  4  current state; drives `UC_ES.Q`.
- `x`  out  2  latched opcode; drives `UC_ES.x`.
- `mem_rd`, `mem_wr`, `ir_we`, `pc_we`  out  1 each  memory and fetch strobes.
- `alu_en`, `alu_src`, `reg_we`, `reg_src_mem`  out  1 each  datapath controls.
- `instr_done`  out  1  one-cycle pulse, registered, per retired instruction.
- `illegal`  out  1  sticky flag; set when `next_state` is outside the legal set.
- `instr_count`  out  `CNT_W`  count of retired instructions.

## Operation
- Legal states are 0–8; 9–15 are illegal.
- State meanings:
  - 0 FETCH
  - 1 DECODE
  - 2 ALU_RR
  - 3 ALU_IMM
  - 4 STORE
  - 5 LOAD
  - 6 WB_ALU
  - 7 MEM_ADDR
  - 8 WB_LOAD
- Transitions come from `UC_ES`:
  - 0→1.
  - 1→2 when x=00; 1→3 when x=01; 1→7 when x=1-.
  - 2→6; 3→6; 6→0.
  - 7→5 when x=10; 7→4 when x=11.
  - 5→8; 8→0; 4→0.
- Wait states are 0, 5 and 4. The block defines `advance = en & ~(wait_state & ~mem_ready)`.
- On `advance`, `Q <= next_state`. If `next_state` > 8, `Q <= 0` and `illegal <= 1` instead.
- If `advance` is 0, `Q` holds.
- Opcode latch: `x <= instr_op` on the edge where Q=0 and `advance`. `x` holds in all other cycles.
- Moore decode of the registered `Q` (combinational, glitch-free from flops):
  - Q=0: `mem_rd`=1; `ir_we = mem_ready & en`.
  - Q=1: `pc_we = en`.
  - Q=2: `alu_en`=1, `alu_src`=0.
  - Q=3 and Q=7: `alu_en`=1, `alu_src`=1.
  - Q=5: `mem_rd`=1.
  - Q=4: `mem_wr`=1.
  - Q=6: `reg_we = en`, `reg_src_mem`=0.
  - Q=8: `reg_we = en`, `reg_src_mem`=1.
  - Every output not listed for a state is 0.
- Retire rule: on an `advance` edge out of state 6, 8 or 4:
  - `instr_count` increments, wrapping 2^CNT_W−1 → 0.
  - `instr_done` is 1 for the following cycle.
  - `instr_done` is 0 in every other cycle.
- `illegal` clears only on `rst`.

## Timing
- Reset values (asserted asynchronously, held while `rst`=1):
  - Q=0, x=00, `instr_count`=0, `instr_done`=0, `illegal`=0.
  - By decode, `mem_rd`=1. All other strobes are 0; `ir_we` is 0 unless `mem_ready & en`.
- Reset mid-operation forces Q=0 immediately. An in-flight `mem_wr` (Q=4) drops without waiting for a clock. The count is cleared and no retire is counted.
- Latency with `mem_ready` held at 1 and `en`=1:
  - ALU_RR / ALU_IMM: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each cycle of `mem_ready`=0 in a wait state adds exactly one cycle.
- `mem_ready` is sampled only in wait states and is ignored elsewhere.
- `en`=0 in a wait state with `mem_ready`=1 does not complete the access: the state holds and `ir_we`=0.
- `next_state` must settle within one cycle of a `Q` change. It is a combinational loop through `UC_ES`, with no added register stage.

## Test plan
- Reset, then with instr_op=00, mem_ready=1, en=1 → Q sequence 0,1,2,6,0. `ir_we` high in cycle 0, `pc_we` in cycle 1, `reg_we` in cycle 3. `instr_done` pulses in cycle 4; `instr_count`=1.
- instr_op=10 with mem_ready low for 3 cycles in state 5 → Q sequence 0,1,7,5,5,5,5,8,0. `mem_rd` high throughout the 5s. `reg_src_mem`=1 in state 8. 8 cycles total.
- instr_op=11, then assert `rst` while Q=4 with mem_ready=0 → `mem_wr` falls asynchronously. Q=0, `instr_count`=0, no `instr_done`.
- Drive `next_state`=10 from the bench while in state 6 → Q=0 and `illegal`=1. After further legal instructions, `illegal` stays 1 until `rst`.
- Set CNT_W=4 and run 17 ALU_IMM instructions → `instr_count` goes 15→0→1 and `instr_done` pulses 17 times.
- Toggle `en`=0 for 2 cycles inside DECODE and inside FETCH with mem_ready=1 → Q, x and count all hold. `pc_we` and `ir_we` are 0 while `en`=0. The sequence resumes unchanged.
